if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage and IF/ID register feeding the decode stage.
//  - Owns the fetch PC and issues requests to the instruction memory over a req/ack handshake.
//  - Buffers returned words in a small FIFO and presents {pc, inst} to decode.
//  - Applies decode-resolved branch/jump redirects and pipeline stalls from the control unit.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  DEPTH     2              prefetch FIFO entries (power of two, >=2)
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active-high
//  stall_i          in   1   hold IF/ID register; do not pop FIFO
//  branch_flag_i    in   1   redirect request from decode (taken branch/JAL/JALR)
//  branch_target_i  in   32  redirect target; bits[1:0] ignored, forced 2'b00
//  imem_req_o       out  1   fetch request valid
//  imem_addr_o      out  32  fetch address, word aligned
//  imem_ack_i       in   1   request accepted; imem_rdata_i valid this cycle
//  imem_rdata_i     in   32  fetched instruction word
//  id_valid_o       out  1   id_inst_o is a real fetched instruction
//  id_pc_o          out  32  PC of id_inst_o
//  id_inst_o        out  32  instruction to decode (NOP 32'h0000_0013 when invalid)
// BEHAVIOUR
//  Reset (clk edge with rst=1), all cycles while rst=1:
//  - fetch_pc=RESET_PC; FIFO empty; FSM=RUN; imem_req_o=0.
//  - id_valid_o=0, id_pc_o=0, id_inst_o=32'h0000_0013.
//  - A pending request is abandoned on reset; memory must tolerate req dropping.
//  Handshake:
//  - Once imem_req_o=1, it and imem_addr_o stay stable until an imem_ack_i cycle.
//  - At most one request outstanding.
//  - Issue condition: count + pending < DEPTH.
//  FSM:
//  - RUN: req=issue-condition; addr=fetch_pc.
//    - ack w/o redirect: push {fetch_pc, rdata}; fetch_pc += 4.
//  - DROP: entered when branch_flag_i=1 while a request is pending and not acked that cycle.
//    - req held at old addr; on ack, discard data; return to RUN.
//  - fetch_pc <= target on the redirect cycle in all cases.
//  - Redirect + ack in same cycle: data discarded, stay RUN, next req to target.
//  IF/ID register update each clk (priority order):
//  1. branch_flag_i=1: FIFO flushed; id_valid_o=0, id_inst_o=NOP, id_pc_o=0. Wins over stall_i.
//  2. stall_i=1: outputs hold; FIFO not popped (may still fill).
//  3. count>0: load head into outputs, id_valid_o=1, pop.
//  4. else: id_valid_o=0, id_inst_o=NOP.
//  Timing:
//  - Push and pop in the same cycle allowed; count unchanged.
//  - FIFO pointers wrap mod DEPTH.
//  - No bypass: ack in cycle N -> id_* in cycle N+1 at earliest.
//  - Sustained throughput: 1 instr/clk with imem_ack_i tied high.
//  - fetch_pc wraps 32'hFFFF_FFFC -> 0.
// TESTING
//  1. Reset
//     - rst high 3 clk, ack=1 -> req=0, id_valid=0, id_inst=0x13.
//     - After release: req=1, addr=RESET_PC.
//  2. Steady fetch
//     - ack tied 1, rdata=addr+0x1000 -> id_pc 0,4,8,... one per clk.
//     - id_inst 0x1000,0x1004,...; no gaps.
//  3. Stall and backpressure
//     - stall_i=1 for 5 clk -> id_* frozen; FIFO fills to DEPTH; req drops to 0.
//     - Release -> buffered entries drain in order, no loss or duplication.
//  4. Redirect with pending request
//     - ack delayed, addr=0x8 pending; branch to 0x103 -> next clk id_valid=0.
//     - 0x8 data dropped on ack; next req addr=0x100; first id_pc=0x100.
//  5. Redirect + stall + ack same cycle
//     - id_inst=NOP, FIFO count=0, ack data discarded.
//     - Next req addr=target.
//  6. Reset during wait
//     - rst while req pending at 0x40 -> req=0 next clk.
//     - After release addr=RESET_PC; no stale entries reach decode.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel, control inputs and IF/ID outputs.
// No storage of its own; timing is set entirely by if_fetch.
// Memory side backpressures through imem_ack_i; decode side through stall_i.
interface if_fetch_if;
    // control-unit / decode inputs
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    // instruction-memory channel
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    // IF/ID register outputs
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    // fetch stage side
    modport master (
        input  stall_i, branch_flag_i, branch_target_i, imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );

    // environment side (memory + decode/control)
    modport slave (
        output stall_i, branch_flag_i, branch_target_i, imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches over req/ack, buffers words, drives the IF/ID register.
// Latency: ack in cycle N is written to the FIFO at that edge and reaches id_* one edge later.
// Backpressure: stall_i freezes IF/ID; the FIFO keeps filling and req drops once it would overflow.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic       clk,
    input logic       rst,
    if_fetch_if.master bus_io
);
    localparam int          CW       = $clog2(DEPTH);
    localparam logic [CW:0] FULL     = (CW+1)'(DEPTH);
    localparam logic [CW:0] CNT_ONE  = (CW+1)'(1);
    localparam logic [CW-1:0] PTR_ONE = CW'(1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic {
        S_RUN,
        S_DROP
    } state_e;

    // fetch side state
    state_e      state_q;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        req_q;
    logic [31:0] addr_q;

    // prefetch FIFO
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [CW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW:0]   count_q, count_d;

    // IF/ID register
    logic        id_valid_q;
    logic [31:0] id_pc_q, id_inst_q;

    logic        ack_fire, push, pop, flush, req_hold;
    logic [31:0] target_aligned;
    logic        unused_tgt_lsb;

    assign unused_tgt_lsb = ^bus_io.branch_target_i[1:0];
    assign target_aligned = {bus_io.branch_target_i[31:2], 2'b00};

    // A request completes only on an ack while it is being driven.
    assign ack_fire = req_q & bus_io.imem_ack_i;
    // Data from a redirected or dropped fetch never enters the FIFO.
    assign push     = ack_fire & (state_q == S_RUN) & ~bus_io.branch_flag_i;
    assign flush    = bus_io.branch_flag_i;
    assign pop      = ~bus_io.branch_flag_i & ~bus_io.stall_i & (count_q != '0);
    // Request still outstanding after this edge: req/addr must not move.
    assign req_hold = req_q & ~bus_io.imem_ack_i;

    // Next FIFO occupancy and next fetch PC
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        fetch_pc_d = fetch_pc_q;
        if (bus_io.branch_flag_i) begin
            fetch_pc_d = target_aligned;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // Fetch FSM: RUN issues requests, DROP waits out a request made stale by a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (req_hold) begin
                if (bus_io.branch_flag_i) begin
                    state_q <= S_DROP;
                end
            end else begin
                // no request in flight after this edge: issue if the FIFO has room for its data
                state_q <= S_RUN;
                req_q   <= (count_d < FULL);
                addr_q  <= fetch_pc_d;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
            fifo_inst_q[wr_ptr_q] <= bus_io.imem_rdata_i;
        end
    end

    // IF/ID register: redirect beats stall beats load beats bubble
    always_ff @(posedge clk) begin
        if (rst || bus_io.branch_flag_i) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP;
        end else if (bus_io.stall_i) begin
            id_valid_q <= id_valid_q;
        end else if (count_q != '0) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= fifo_pc_q[rd_ptr_q];
            id_inst_q  <= fifo_inst_q[rd_ptr_q];
        end else begin
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP;
        end
    end

    assign bus_io.imem_req_o  = req_q;
    assign bus_io.imem_addr_o = addr_q;
    assign bus_io.id_valid_o  = id_valid_q;
    assign bus_io.id_pc_o     = id_pc_q;
    assign bus_io.id_inst_o   = id_inst_q;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table from reset, then random traffic against a stream model.
// Memory returns addr+0x1000 combinationally whenever it acks.
// Model: delivered instructions must be consecutive words starting at the last redirect target.
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ctl = {rst, stall, branch, ack}; ex = {req, valid, check_pc}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] tgt;
        logic [2:0]  ex;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    if_fetch_if ifc();

    if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (ifc)
    );

    always #5 clk = ~clk;

    assign ifc.imem_rdata_i = ifc.imem_addr_o + 32'h0000_1000;

    int          n_chk  = 0;
    int          n_fail = 0;
    vec_t        vq[$];
    logic [31:0] exp_pc;
    logic        p_req, p_vld;
    logic [31:0] p_addr, p_pc, p_inst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic [31:0] t, input logic [2:0] e,
                       input logic [31:0] a, input logic [31:0] p, input logic [31:0] i);
        vec_t v;
        v.ctl = c; v.tgt = t; v.ex = e; v.addr = a; v.pc = p; v.inst = i;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [31:0] t, input logic a);
        rst                 = r;
        ifc.stall_i         = s;
        ifc.branch_flag_i   = b;
        ifc.branch_target_i = t;
        ifc.imem_ack_i      = a;
    endtask

    // One clock of free-running traffic checked against the stream model.
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic a);
        p_req  = ifc.imem_req_o;
        p_addr = ifc.imem_addr_o;
        p_vld  = ifc.id_valid_o;
        p_pc   = ifc.id_pc_o;
        p_inst = ifc.id_inst_o;
        drive(1'b0, s, b, t, a);
        @(posedge clk);
        @(negedge clk);
        if (p_req && !a) begin
            chk("hs.req_hold", 32'(ifc.imem_req_o), 32'd1);
            chk("hs.addr_hold", ifc.imem_addr_o, p_addr);
        end
        if (ifc.imem_req_o)
            chk("hs.addr_align", 32'(ifc.imem_addr_o[1:0]), 32'd0);
        if (b) begin
            chk("br.valid", 32'(ifc.id_valid_o), 32'd0);
            chk("br.inst", ifc.id_inst_o, NOP);
            chk("br.pc", ifc.id_pc_o, 32'h0);
            exp_pc = {t[31:2], 2'b00};
        end else if (s) begin
            chk("stall.valid", 32'(ifc.id_valid_o), 32'(p_vld));
            chk("stall.pc", ifc.id_pc_o, p_pc);
            chk("stall.inst", ifc.id_inst_o, p_inst);
        end else if (ifc.id_valid_o) begin
            chk("stream.pc", ifc.id_pc_o, exp_pc);
            chk("stream.inst", ifc.id_inst_o, exp_pc + 32'h0000_1000);
            exp_pc = exp_pc + 32'd4;
        end else begin
            chk("bubble.inst", ifc.id_inst_o, NOP);
        end
    endtask

    initial begin
        int   quiet;
        logic got;

        // reset (3 clk with ack high), then steady fetch
        add(4'b1001, 32'h0,   3'b001, 32'h0,   32'h0,   NOP);
        add(4'b1001, 32'h0,   3'b001, 32'h0,   32'h0,   NOP);
        add(4'b1001, 32'h0,   3'b001, 32'h0,   32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b101, 32'h0,   32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b101, 32'h4,   32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b111, 32'h8,   32'h0,   32'h1000);
        add(4'b0001, 32'h0,   3'b111, 32'hC,   32'h4,   32'h1004);
        // stall 5 clk: outputs frozen, FIFO fills to 2 entries, req drops
        add(4'b0101, 32'h0,   3'b011, 32'h0,   32'h4,   32'h1004);
        add(4'b0101, 32'h0,   3'b011, 32'h0,   32'h4,   32'h1004);
        add(4'b0101, 32'h0,   3'b011, 32'h0,   32'h4,   32'h1004);
        add(4'b0101, 32'h0,   3'b011, 32'h0,   32'h4,   32'h1004);
        add(4'b0101, 32'h0,   3'b011, 32'h0,   32'h4,   32'h1004);
        // release: buffered 0x8, 0xC drain in order
        add(4'b0001, 32'h0,   3'b111, 32'h10,  32'h8,   32'h1008);
        add(4'b0001, 32'h0,   3'b111, 32'h14,  32'hC,   32'h100C);
        // ack withheld so 0x14 is pending, then redirect to 0x103
        add(4'b0000, 32'h0,   3'b111, 32'h14,  32'h10,  32'h1010);
        add(4'b0010, 32'h103, 3'b101, 32'h14,  32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b101, 32'h100, 32'h0,   NOP);
        add(4'b0000, 32'h0,   3'b101, 32'h100, 32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b101, 32'h104, 32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b111, 32'h108, 32'h100, 32'h1100);
        // redirect + stall + ack in one cycle
        add(4'b0111, 32'h200, 3'b101, 32'h200, 32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b101, 32'h204, 32'h0,   NOP);
        add(4'b0000, 32'h0,   3'b111, 32'h204, 32'h200, 32'h1200);
        add(4'b0000, 32'h0,   3'b100, 32'h204, 32'h0,   NOP);
        // reset while 0x204 is pending
        add(4'b1000, 32'h0,   3'b001, 32'h0,   32'h0,   NOP);
        add(4'b0000, 32'h0,   3'b101, 32'h0,   32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b101, 32'h4,   32'h0,   NOP);
        add(4'b0001, 32'h0,   3'b111, 32'h8,   32'h0,   32'h1000);

        foreach (vq[k]) begin
            drive(vq[k].ctl[3], vq[k].ctl[2], vq[k].ctl[1], vq[k].tgt, vq[k].ctl[0]);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d.req", k), 32'(ifc.imem_req_o), 32'(vq[k].ex[2]));
            if (vq[k].ex[2])
                chk($sformatf("vec%0d.addr", k), ifc.imem_addr_o, vq[k].addr);
            chk($sformatf("vec%0d.valid", k), 32'(ifc.id_valid_o), 32'(vq[k].ex[1]));
            if (vq[k].ex[0])
                chk($sformatf("vec%0d.pc", k), ifc.id_pc_o, vq[k].pc);
            chk($sformatf("vec%0d.inst", k), ifc.id_inst_o, vq[k].inst);
        end

        // random traffic; periodic redirects near the top of memory exercise PC wrap
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_pc = 32'h0;
        quiet  = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        s, b, a;
            logic [31:0] t;
            s = ($urandom_range(3) == 0);
            b = ($urandom_range(15) == 0);
            a = ($urandom_range(9) < 6);
            t = $urandom;
            if (i % 700 == 50) begin
                b     = 1'b1;
                t     = 32'hFFFF_FFF1;
                quiet = 40;
            end else if (quiet > 0) begin
                b     = 1'b0;
                quiet = quiet - 1;
            end
            step(s, b, t, a);
        end

        // drain with ack tied high: stream must resume and run without gaps
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            got = ifc.id_valid_o;
        end
        chk("drain.valid_within_10", 32'(got), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk("stream.no_gap", 32'(ifc.id_valid_o), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
